mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word address width into the shared memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request; if_addr input ADDR_W, fetch word address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle; if_valid output 1, if_rdata output DATA_W, fetch data return.
REQ-007 d_req  input  1  data request; d_we input 1, write when high; d_addr input ADDR_W; d_wd input DATA_W.
REQ-008 d_gnt  output  1  data request accepted this cycle; d_valid output 1, read data or write ack; d_rdata output DATA_W.
REQ-009 mem_en, mem_we  output  1 each  shared single-port memory strobes; mem_addr output ADDR_W; mem_wd output DATA_W; mem_rd input DATA_W with 1-cycle read latency.
REQ-010 stall  output  1  high when any asserted request is not granted this cycle.
REQ-011 conflict_cnt  output  16  saturating count of cycles in which both if_req and d_req were high.

Function
REQ-012 Arbitration SHALL be combinational in cycle N: at most one of if_gnt/d_gnt high; gnt implies the matching req is high.
REQ-013 Single requester: that requester SHALL be granted in the same cycle; no idle cycle inserted.
REQ-014 On grant, mem_en=1, and mem_addr/mem_we/mem_wd SHALL carry the winner's fields (mem_we=0 for fetch); with no grant, mem_en=0 and mem_we=0.
REQ-015 Owner tag SHALL be registered at cycle N; in cycle N+1 exactly the owner's valid pulses for one cycle, with its rdata = mem_rd.
REQ-016 Data writes SHALL produce d_valid in N+1 as an ack; d_rdata is don't-care for writes.
REQ-017 Back-to-back grants every cycle SHALL be supported (throughput 1 per cycle).
REQ-018 Requesters SHALL hold req and fields stable until gnt; the arbiter SHALL NOT require req to drop between transactions.
REQ-019 Response-side state machine: IDLE (no response due), RESP_I, RESP_D; next state SHALL be RESP_I/RESP_D on fetch/data grant, else IDLE, independent of current state.
REQ-020 stall SHALL equal (if_req & ~if_gnt) | (d_req & ~d_gnt).
REQ-021 conflict_cnt SHALL increment on each cycle with if_req & d_req, and SHALL hold at 16'hFFFF (no wrap).
REQ-022 last_owner register SHALL record the winner on every grant; unchanged when no grant.

Reset
REQ-023 While reset is high: all gnt/valid/mem_en/mem_we/stall outputs 0, rdata outputs 0, conflict_cnt=0, state=IDLE, last_owner=FETCH.
REQ-024 Reset asserted with a response pending SHALL drop the response; no valid pulse after reset release.
REQ-025 First cycle after reset release SHALL arbitrate normally.

Configuration
REQ-026 Macro MEM_ARB_ROUND_ROBIN_EN defined: on conflict, grant the requester that is not last_owner (alternating).
REQ-027 Macro undefined: fixed priority, data always wins a conflict; last_owner still tracked but unused for arbitration.

Verification
REQ-028 if_req=1, addr=0x004, memory[4]=0xDEADBEEF, d_req=0 -> if_gnt same cycle, if_valid next cycle, if_rdata=0xDEADBEEF, stall=0.
REQ-029 d_req=1, d_we=1, addr=0x010, wd=0x12345678 -> mem_we=1 at 0x010, d_valid ack next cycle; subsequent read of 0x010 returns 0x12345678.
REQ-030 Both requesting 4 cycles from reset, RR macro defined -> grants D,I,D,I; stall=1 every cycle; conflict_cnt=4.
REQ-031 Same stimulus, macro undefined -> grants D,D,D,D; if_gnt never high; stall=1 all 4 cycles.
REQ-032 Reset asserted in the cycle after a fetch grant -> no if_valid pulse, all outputs 0 immediately (asynchronous), conflict_cnt=0.
REQ-033 Continuous conflict for 70000 cycles -> conflict_cnt saturates at 0xFFFF and stays there.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester front end for a shared single-port memory.
//
// An instruction-fetch port (read only) and a data port (read/write) compete
// for one memory. Arbitration is purely combinational, so a lone requester is
// granted in the same cycle and a grant can issue every cycle. The winner is
// tagged in a response-side FSM so the matching valid pulses one cycle later,
// aligned with the memory's 1-cycle read latency.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> conflicts alternate between requesters,
//                                        granting whichever was not last owner.
//                           undefined -> fixed priority, data wins conflicts.
//
// Ports:
//   clock, reset                 system clock, async active-high reset
//   if_req/if_addr               fetch request and word address
//   if_gnt/if_valid/if_rdata     fetch accept, response strobe, read data
//   d_req/d_we/d_addr/d_wd       data request, write enable, address, wdata
//   d_gnt/d_valid/d_rdata        data accept, read-data/write-ack strobe, rdata
//   mem_en/mem_we/mem_addr/mem_wd/mem_rd   shared memory interface
//   stall                        some asserted request was not granted
//   conflict_cnt                 saturating count of dual-request cycles

module mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              stall,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e      state_q, state_d;
  owner_e      last_owner_q, last_owner_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict;

  assign conflict = if_req & d_req;

  // Grant and memory-strobe logic. Everything on the request side is gated by
  // reset so that grants, strobes and stall read zero while reset is held.
  always_comb begin
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    if (!reset) begin
      if (conflict) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (last_owner_q == OWN_DATA) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
`else
        d_gnt = 1'b1;
`endif
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end

    mem_en   = if_gnt | d_gnt;
    mem_we   = d_gnt & d_we;
    mem_addr = '0;
    mem_wd   = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_wd   = d_wd;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end

    stall = ~reset & ((if_req & ~if_gnt) | (d_req & ~d_gnt));
  end

  // Next-state: response tag follows this cycle's grant regardless of the
  // current state, which is what allows a new grant every cycle.
  always_comb begin
    state_d        = IDLE;
    last_owner_d   = last_owner_q;
    conflict_cnt_d = conflict_cnt_q;
    if (if_gnt) begin
      state_d      = RESP_I;
      last_owner_d = OWN_FETCH;
    end else if (d_gnt) begin
      state_d      = RESP_D;
      last_owner_d = OWN_DATA;
    end
    if (conflict && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_owner_q   <= OWN_FETCH;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Response side: the owner's valid pulses and its rdata carries mem_rd;
  // the other port's rdata stays zero.
  always_comb begin
    if_valid = (state_q == RESP_I);
    d_valid  = (state_q == RESP_D);
    if_rdata = if_valid ? mem_rd : '0;
    d_rdata  = d_valid  ? mem_rd : '0;
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule
